// File: rtl/dll_lock_ctrl_pkg.sv
// Shared types for the DLL loop controller: FSM states, mode codes and step directions.
package dll_lock_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQUIRE = 3'd1,
        TRACK   = 3'd2,
        HOLD    = 3'd3,
        MANUAL  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_MANUAL = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2
    } step_t;

    // State a mode request leads to from IDLE/MANUAL; the reserved code behaves as HOLD.
    function automatic state_t mode_target(input logic [1:0] mode);
        case (mode)
            MODE_AUTO:   return ACQUIRE;
            MODE_MANUAL: return MANUAL;
            default:     return HOLD;
        endcase
    endfunction

endpackage

// File: rtl/dll_lock_ctrl_if.sv
// Control/status bundle between the phase detector side and the DLL loop controller.
interface dll_lock_ctrl_if #(
    parameter int TAP_W = 5
);
    import dll_lock_ctrl_pkg::*;

    logic             en;
    logic [1:0]       mode;
    logic [TAP_W-1:0] manual_code;
    logic             pd_valid;
    logic             pd_late;
    logic [TAP_W-1:0] tap_code;
    logic             locked;
    state_t           state;
    logic             sat;

    modport master (
        output en, mode, manual_code, pd_valid, pd_late,
        input  tap_code, locked, state, sat
    );

    modport slave (
        input  en, mode, manual_code, pd_valid, pd_late,
        output tap_code, locked, state, sat
    );

endinterface

// File: rtl/dll_lock_ctrl_window_acc.sv
// Counts 2**WIN_W valid PD samples, accumulates early(+1)/late(-1) votes and
// reports the step decision on the cycle of the last sample of the window.
module dll_lock_ctrl_window_acc
    import dll_lock_ctrl_pkg::*;
#(
    parameter int WIN_W    = 3,
    parameter int DEADBAND = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  active,
    input  logic  sample,
    input  logic  late,
    output logic  win_done,
    output step_t step,
    output logic  balanced
);
    localparam int ACC_W = WIN_W + 2;
    localparam logic signed [ACC_W-1:0] ONE    = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] DB_POS = ACC_W'(DEADBAND);
    localparam logic signed [ACC_W-1:0] DB_NEG = -DB_POS;

    logic [WIN_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum;

    // Sum including the current sample, so the window decision sees all 2**WIN_W votes.
    assign acc_sum  = late ? (acc_q - ONE) : (acc_q + ONE);
    assign win_done = active && sample && (cnt_q == '1);

    // Step decision is only meaningful on the window-closing cycle; otherwise report none.
    always_comb begin
        step = STEP_NONE;
        if (win_done) begin
            if (acc_sum > DB_POS)      step = STEP_UP;
            else if (acc_sum < DB_NEG) step = STEP_DN;
        end
    end

    assign balanced = win_done && (step == STEP_NONE);

    // Sample counter and accumulator; held at zero whenever the loop is not actively tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (!active) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (sample) begin
            if (cnt_q == '1) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= acc_sum;
            end
        end
    end

endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL loop controller: mode FSM, saturating tap-code register and lock/unlock run detection.
module dll_lock_ctrl
    import dll_lock_ctrl_pkg::*;
#(
    parameter int TAP_W      = 5,
    parameter int WIN_W      = 3,
    parameter int DEADBAND   = 1,
    parameter int LOCK_WIN   = 4,
    parameter int UNLOCK_WIN = 3,
    parameter int RESET_CODE = 16
) (
    input logic            clk,
    input logic            rst,
    dll_lock_ctrl_if.slave bus
);
    localparam int RUN_MAX = (LOCK_WIN > UNLOCK_WIN) ? LOCK_WIN : UNLOCK_WIN;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [TAP_W-1:0] TAP_MAX  = '1;
    localparam logic [TAP_W-1:0] TAP_RST  = TAP_W'(RESET_CODE);
    localparam logic [RUN_W-1:0] LOCK_N   = RUN_W'(LOCK_WIN);
    localparam logic [RUN_W-1:0] UNLOCK_N = RUN_W'(UNLOCK_WIN);

    state_t           state_q, state_nxt;
    logic [TAP_W-1:0] tap_q, tap_nxt;
    logic             locked_q, locked_nxt;
    logic             sat_q, sat_nxt;
    logic [RUN_W-1:0] set_q, set_nxt, set_inc;
    logic [RUN_W-1:0] unl_q, unl_nxt, unl_inc;
    step_t            prev_q, prev_nxt;
    step_t            dir_q, dir_nxt;

    logic  acc_active, win_done, balanced;
    logic  clip, applied, settled;
    step_t step;

    // A mode change on a window-closing cycle drops acc_active, so the step is discarded.
    assign acc_active = bus.en && (bus.mode == MODE_AUTO) &&
                        ((state_q == ACQUIRE) || (state_q == TRACK));

    dll_lock_ctrl_window_acc #(
        .WIN_W    (WIN_W),
        .DEADBAND (DEADBAND)
    ) u_win (
        .clk      (clk),
        .rst      (rst),
        .active   (acc_active),
        .sample   (bus.pd_valid),
        .late     (bus.pd_late),
        .win_done (win_done),
        .step     (step),
        .balanced (balanced)
    );

    assign clip    = ((step == STEP_UP) && (tap_q == TAP_MAX)) ||
                     ((step == STEP_DN) && (tap_q == '0));
    assign applied = (step != STEP_NONE) && !clip;
    // Settled: no step, or a real step that reverses the last real step (dithering around lock).
    assign settled = balanced ||
                     (applied && (prev_q != STEP_NONE) && (step != prev_q));
    assign set_inc = set_q + 1'b1;
    // Clipped steps still extend the same-direction run used for unlock.
    assign unl_inc = ((unl_q != '0) && (step == dir_q)) ? (unl_q + 1'b1) : RUN_W'(1);

    // State and loop registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tap_q    <= TAP_RST;
            locked_q <= 1'b0;
            sat_q    <= 1'b0;
            set_q    <= '0;
            unl_q    <= '0;
            prev_q   <= STEP_NONE;
            dir_q    <= STEP_NONE;
        end else begin
            state_q  <= state_nxt;
            tap_q    <= tap_nxt;
            locked_q <= locked_nxt;
            sat_q    <= sat_nxt;
            set_q    <= set_nxt;
            unl_q    <= unl_nxt;
            prev_q   <= prev_nxt;
            dir_q    <= dir_nxt;
        end
    end

    // Next-state, tap update with saturation, and lock/unlock run tracking.
    always_comb begin
        state_nxt  = state_q;
        tap_nxt    = tap_q;
        locked_nxt = locked_q;
        sat_nxt    = 1'b0;
        set_nxt    = set_q;
        unl_nxt    = unl_q;
        prev_nxt   = prev_q;
        dir_nxt    = dir_q;
        if (!bus.en) begin
            state_nxt  = IDLE;
            locked_nxt = 1'b0;
            set_nxt    = '0;
            unl_nxt    = '0;
            prev_nxt   = STEP_NONE;
            dir_nxt    = STEP_NONE;
        end else begin
            case (state_q)
                IDLE: state_nxt = mode_target(bus.mode);
                ACQUIRE, TRACK: begin
                    if (bus.mode != MODE_AUTO) begin
                        state_nxt = mode_target(bus.mode);
                        set_nxt   = '0;
                        unl_nxt   = '0;
                        prev_nxt  = STEP_NONE;
                        dir_nxt   = STEP_NONE;
                    end else if (win_done) begin
                        sat_nxt = clip;
                        if (applied) begin
                            tap_nxt  = (step == STEP_UP) ? (tap_q + 1'b1) : (tap_q - 1'b1);
                            prev_nxt = step;
                        end
                        if (state_q == ACQUIRE) begin
                            if (!settled) begin
                                set_nxt = '0;
                            end else if (set_inc >= LOCK_N) begin
                                state_nxt  = TRACK;
                                locked_nxt = 1'b1;
                                set_nxt    = '0;
                                unl_nxt    = '0;
                                dir_nxt    = STEP_NONE;
                            end else begin
                                set_nxt = set_inc;
                            end
                        end else begin
                            if (step == STEP_NONE) begin
                                unl_nxt = '0;
                            end else if (unl_inc >= UNLOCK_N) begin
                                state_nxt  = ACQUIRE;
                                locked_nxt = 1'b0;
                                unl_nxt    = '0;
                                set_nxt    = '0;
                                dir_nxt    = STEP_NONE;
                            end else begin
                                unl_nxt = unl_inc;
                                dir_nxt = step;
                            end
                        end
                    end
                end
                HOLD: state_nxt = ((bus.mode == MODE_AUTO) && locked_q) ? TRACK
                                                                        : mode_target(bus.mode);
                MANUAL: state_nxt = mode_target(bus.mode);
                default: state_nxt = IDLE;
            endcase
            if (state_nxt == MANUAL) begin
                tap_nxt    = bus.manual_code;
                locked_nxt = 1'b0;
            end
        end
    end

    assign bus.tap_code = tap_q;
    assign bus.locked   = locked_q;
    assign bus.state    = state_q;
    assign bus.sat      = sat_q;

endmodule
